// File: rtl/hpdl1414_write_sequencer.sv
// HPDL-1414 write sequencer: scans a 16-character buffer and drives four
// displays with explicit setup / strobe / hold timed write cycles.
module hpdl1414_write_sequencer #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned PULSE_CYC  = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned BLINK_BITS = 23,
    parameter logic [7:0]  CARET_CHAR = 8'h5F
) (
    input  logic       CLK_i,
    input  logic       RST_i,
    input  logic       i_enable,
    output logic [3:0] o_rd_addr,
    input  logic [7:0] i_rd_data,
    input  logic [3:0] i_caret_pos,
    input  logic       i_caret_en,
    output logic [6:0] HPDL_D,
    output logic [1:0] HPDL_A,
    output logic [3:0] HPDL_WR,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int unsigned MAX_SP =
        (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_CYC =
        (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int unsigned CW =
        (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            pos_q, pos_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [6:0]            d_q, d_d;
    logic [1:0]            a_q, a_d;
    logic [3:0]            wr_q, wr_d;
    logic                  fd_q, fd_d;
    logic [BLINK_BITS-1:0] blink_q;
    logic                  caret_hit;
    logic [6:0]            mapped;

    // Character sanitising; caret wins over the buffer contents.
    always_comb begin
        caret_hit = i_caret_en && blink_q[BLINK_BITS-1]
                    && (pos_q == i_caret_pos);
        mapped = 7'h20;
        if (caret_hit) begin
            mapped = CARET_CHAR[6:0];
        end else if (i_rd_data >= 8'h20 && i_rd_data <= 8'h5F) begin
            mapped = i_rd_data[6:0];
        end else if (i_rd_data >= 8'h61 && i_rd_data <= 8'h7A) begin
            mapped = i_rd_data[6:0] - 7'h20;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        a_d     = a_q;
        fd_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                d_d     = mapped;
                a_d     = ~pos_q[1:0];
                cnt_d   = '0;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    pos_d   = pos_q + 4'd1;
                    fd_d    = (pos_q == 4'd15);
                    state_d = i_enable ? S_FETCH : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // WR is decoded from the next state so the strobe is a clean register.
    always_comb begin
        wr_d = 4'hF;
        if (state_d == S_STROBE) wr_d[pos_q[3:2]] = 1'b0;
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q <= S_IDLE;
            pos_q   <= 4'd0;
            cnt_q   <= '0;
            d_q     <= 7'd0;
            a_q     <= 2'b11;
            wr_q    <= 4'hF;
            fd_q    <= 1'b0;
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            a_q     <= a_d;
            wr_q    <= wr_d;
            fd_q    <= fd_d;
            blink_q <= blink_q + BLINK_BITS'(1);
        end
    end

    assign o_rd_addr    = pos_q;
    assign HPDL_D       = d_q;
    assign HPDL_A       = a_q;
    assign HPDL_WR      = wr_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = fd_q;

endmodule

// File: doc/hpdl1414_write_sequencer.md
Name: hpdl1414_write_sequencer

Overview:
Downstream stage of the UART character memory. It scans a 16-entry character buffer through a synchronous read port and drives four HPDL-1414 devices (4 digits each) with timed address, data and active-low write strobes. Character sanitising and caret blinking are done inside the block. It replaces the free-running counter-derived WR strobes with an explicit setup/pulse/hold sequence on the system clock.

Parameters:
SETUP_CYC, 2, cycles that address and data are stable before WR falls (min 1)
PULSE_CYC, 4, cycles that WR is held low (min 1; 4 cycles = 333 ns at 12 MHz)
HOLD_CYC, 2, cycles that address and data are held after WR rises (min 1)
BLINK_BITS, 23, width of the free-running blink counter; its MSB is the caret phase
CARET_CHAR, 8'h5F, character shown at the caret position during the caret-on phase

Ports:
CLK_i  input  1  system clock, 12 MHz
RST_i  input  1  asynchronous, active-high reset
i_enable  input  1  1 = refresh continuously; 0 = stop after the current digit
o_rd_addr  output  4  character buffer read address (buffer data returns 1 cycle later)
i_rd_data  input  8  character buffer read data
i_caret_pos  input  4  buffer index of the caret
i_caret_en  input  1  caret display enable
HPDL_D  output  7  display data bus D6..D0
HPDL_A  output  2  digit address inside the device, inverted (A = ~pos[1:0])
HPDL_WR  output  4  active-low write strobe; bit n selects device n (pos[3:2] == n)
o_busy  output  1  high whenever the state is not IDLE
o_frame_done  output  1  1-cycle pulse after digit 15 completes its HOLD phase

Behaviour:
- Reset (async assert, sync release) values: state IDLE, pos=0, o_rd_addr=0, HPDL_D=0, HPDL_A=2'b11, HPDL_WR=4'b1111, o_busy=0, o_frame_done=0, blink counter=0, cycle counter=0. If reset asserts during STROBE, WR must go high immediately, not at the next edge.
- Blink counter: free-running, wraps at 2^BLINK_BITS. caret_on = blink[BLINK_BITS-1].
- FSM states: IDLE, FETCH, LATCH, SETUP, STROBE, HOLD.
  - IDLE: if i_enable=1, go to FETCH with o_rd_addr=pos.
  - FETCH: 1 cycle. Waits for the read latency.
  - LATCH: 1 cycle. Registers the mapped character into HPDL_D, drives HPDL_A=~pos[1:0], then goes to SETUP.
  - SETUP: SETUP_CYC cycles.
  - STROBE: PULSE_CYC cycles. HPDL_WR[pos[3:2]]=0 and all other WR bits are 1.
  - HOLD: HOLD_CYC cycles with all WR=1 and D/A unchanged.
  - HOLD exit: pos increments mod 16. If i_enable=1, go to FETCH; otherwise go to IDLE.
- Digit period is 2+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (10 with defaults). Frame period is 16 digit periods (160 cycles).
- WR is registered and glitch-free. No more than one WR bit is ever low. D and A change only in LATCH, when all WR are 1.
- Character mapping (checked in this order, applied to the latched byte b):
  - caret substitution: if i_caret_en=1, caret_on=1 and pos==i_caret_pos, output CARET_CHAR[6:0];
  - else if 0x20<=b<=0x5F, output b[6:0];
  - else if 0x61<=b<=0x7A, output b-0x20 (upper-case);
  - else output 0x20 (space). Bit 7 is never driven.
- caret_on is sampled in LATCH. A phase change mid-digit takes effect on the next digit written.
- o_frame_done pulses in the cycle after the HOLD exit of pos=15, whether or not the FSM continues.
- Deasserting i_enable mid-digit completes that digit (no truncated WR pulse). Reasserting it in IDLE resumes at the current pos, not at 0.
- i_caret_pos and i_caret_en are sampled only in LATCH. They may change at any time.

Test Plan:
- Reset, then i_enable=1 with buffer "HELLO" padded with spaces. Required: 16 WR pulses per 160-cycle frame. Digit 0 writes D=0x48 with A=2'b11 on WR[0]; digit 5 writes A=2'b10 on WR[1]; each WR low for exactly 4 cycles; D/A stable 2 cycles before and after each pulse; o_frame_done on cycle 160.
- Buffer holds 0x61 ('a'), 0x7B, 0x0D, 0x5F. Required: D=0x41, 0x20, 0x20, 0x5F respectively.
- BLINK_BITS=4, i_caret_en=1, i_caret_pos=3, buffer all 0x41. Required: digit 3 shows 0x5F during frames where blink MSB=1 at LATCH and 0x41 otherwise; other digits always show 0x41.
- i_enable dropped during STROBE of digit 6. Required: the pulse completes its full 4 cycles, HOLD completes, then IDLE with o_busy=0 and pos=7; re-enable resumes with o_rd_addr=7.
- RST_i pulsed asynchronously mid-STROBE. Required: HPDL_WR=4'b1111 before the next clock edge, all outputs at reset values, and the first write after release is digit 0.
- SETUP_CYC=1, PULSE_CYC=1, HOLD_CYC=1. Required: 5-cycle digit period, 80-cycle frame, and never two WR bits low at once.
